ball_motion_ctrl: RTL and testbench

//  Per-frame ball position generator; directly upstream of the circle-collision check.

---
 rtl/ball_motion_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//   Per-frame ball position generator that feeds a combinational circle
//   collision checker. Once per frame_tick the ball steps by 'speed' pixels
//   per axis and bounces off the screen walls. The checker's verdict on the
//   new position is sampled two cycles later; a hit restores the previous
//   position and reverses the horizontal direction.
//
//   Optional feature macro: MISS_DETECT_EN
//     When defined, touching the left or right wall is a miss. The ball is
//     re-served at (X0, Y0), dirX toggles, a 1-cycle 'miss' pulse is
//     raised and the controller returns to IDLE. The Y walls still bounce.
//     When undefined, all four walls bounce and the 'miss' port is absent.
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
  parameter int posBits    = 9,
  parameter int dimBits    = 8,
  parameter int SPEED_BITS = 4,
  parameter int X_MAX      = 399,
  parameter int Y_MAX      = 299,
  parameter int X0         = 200,
  parameter int Y0         = 150
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic [dimBits-1:0]    radius,
  input  logic [SPEED_BITS-1:0] speed,
  input  logic                  collision,
  output logic [posBits-1:0]    posX,
  output logic [posBits-1:0]    posY,
  output logic                  dirX,
  output logic                  dirY,
  output logic                  moving,
  output logic                  bounce
`ifdef MISS_DETECT_EN
  ,
  output logic                  miss
`endif
);

  // One extra bit so pos+speed and radius+speed never wrap.
  localparam int EW = posBits + 1;

  localparam logic [posBits-1:0] X_SERVE = posBits'(X0);
  localparam logic [posBits-1:0] Y_SERVE = posBits'(Y0);
  localparam logic [EW-1:0]      X_LIM   = EW'(X_MAX);
  localparam logic [EW-1:0]      Y_LIM   = EW'(Y_MAX);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    STEP,
    SETTLE,
    RESOLVE
  } state_t;

  // Result of advancing one axis by one frame.
  typedef struct packed {
    logic [posBits-1:0] pos;
    logic               dir;
    logic               hit;   // wall contact on this axis
  } axis_t;

  // Advance one axis: clamp to the wall and reverse on contact, otherwise
  // move by spd. A frozen ball (spd == 0) never registers a wall contact.
  function automatic axis_t axis_step(
    input logic [posBits-1:0] pos,
    input logic               dir,
    input logic [EW-1:0]      lim,
    input logic [EW-1:0]      rad,
    input logic [EW-1:0]      spd
  );
    axis_t         r;
    logic [EW-1:0] p;
    logic [EW-1:0] hi;
    logic [EW-1:0] lo;
    logic [EW-1:0] sum;
    logic [EW-1:0] diff;
    p     = {1'b0, pos};
    hi    = lim - rad;
    lo    = rad + spd;
    sum   = p + spd;
    diff  = p - spd;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir) begin
      if ((spd != '0) && (sum > hi)) begin
        r.pos = hi[posBits-1:0];
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = sum[posBits-1:0];
      end
    end else begin
      if ((spd != '0) && (p < lo)) begin
        r.pos = rad[posBits-1:0];
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = diff[posBits-1:0];
      end
    end
    return r;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [posBits-1:0] prev_x_q;
  logic [posBits-1:0] prev_y_q;
  logic [posBits-1:0] prev_x_d;
  logic [posBits-1:0] prev_y_d;
  logic [posBits-1:0] pos_x_d;
  logic [posBits-1:0] pos_y_d;
  logic               dir_x_d;
  logic               dir_y_d;
  logic               bounce_d;
  logic               moving_d;
  logic               x_miss;
  axis_t              ax;
  axis_t              ay;
`ifdef MISS_DETECT_EN
  logic               miss_d;
`endif

  // Candidate per-axis step from the current position; only committed in STEP.
  always_comb begin
    ax = axis_step(posX, dirX, X_LIM, EW'(radius), EW'(speed));
    ay = axis_step(posY, dirY, Y_LIM, EW'(radius), EW'(speed));
  end

`ifdef MISS_DETECT_EN
  assign x_miss = ax.hit;
`else
  assign x_miss = 1'b0;
`endif

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Ticks outside WAIT_TICK are dropped, never queued.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start)      state_d = WAIT_TICK;
      WAIT_TICK: if (frame_tick) state_d = STEP;
      STEP:      state_d = x_miss ? IDLE : SETTLE;
      SETTLE:    state_d = RESOLVE;
      RESOLVE:   state_d = WAIT_TICK;
      default:   state_d = IDLE;
    endcase
  end

  // Output/datapath logic: next values of the registered outputs.
  always_comb begin
    pos_x_d  = posX;
    pos_y_d  = posY;
    dir_x_d  = dirX;
    dir_y_d  = dirY;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    bounce_d = 1'b0;
`ifdef MISS_DETECT_EN
    miss_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        pos_x_d = X_SERVE;
        pos_y_d = Y_SERVE;
      end
      STEP: begin
        prev_x_d = posX;
        prev_y_d = posY;
        if (x_miss) begin
          // Re-serve: centre the ball and send it back the other way.
          pos_x_d = X_SERVE;
          pos_y_d = Y_SERVE;
          dir_x_d = ~dirX;
`ifdef MISS_DETECT_EN
          miss_d  = 1'b1;
`endif
        end else begin
          pos_x_d  = ax.pos;
          pos_y_d  = ay.pos;
          dir_x_d  = ax.dir;
          dir_y_d  = ay.dir;
          bounce_d = ax.hit | ay.hit;
        end
      end
      RESOLVE: begin
        // A hit undoes the whole step, including any wall clamp, and flips dirX
        // relative to whatever the step left it at.
        if (collision) begin
          pos_x_d  = prev_x_q;
          pos_y_d  = prev_y_q;
          dir_x_d  = ~dirX;
          bounce_d = 1'b1;
        end
      end
      default: ;
    endcase
    moving_d = (state_d != IDLE);
  end

  // Registered outputs and saved previous position; reset discards any partial step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posX     <= X_SERVE;
      posY     <= Y_SERVE;
      dirX     <= 1'b1;
      dirY     <= 1'b1;
      prev_x_q <= X_SERVE;
      prev_y_q <= Y_SERVE;
      moving   <= 1'b0;
      bounce   <= 1'b0;
`ifdef MISS_DETECT_EN
      miss     <= 1'b0;
`endif
    end else begin
      posX     <= pos_x_d;
      posY     <= pos_y_d;
      dirX     <= dir_x_d;
      dirY     <= dir_y_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      moving   <= moving_d;
      bounce   <= bounce_d;
`ifdef MISS_DETECT_EN
      miss     <= miss_d;
`endif
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//   Frame-level bench for ball_motion_ctrl. Each table row is one frame:
//   the inputs for that frame and the hand-derived position/direction after
//   it, plus how many bounce pulses the frame must produce. Rows are pushed
//   into a scoreboard queue when the tick is driven and popped when the frame
//   has resolved. Reset, dropped-tick and miss cases are hand-written.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic [7:0] radius;
  logic [3:0] speed;
  logic       collision;
  logic [8:0] posX;
  logic [8:0] posY;
  logic       dirX;
  logic       dirY;
  logic       moving;
  logic       bounce;
`ifdef MISS_DETECT_EN
  logic       miss;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] spd;
    logic [7:0] rad;
    logic       coll;
    logic [8:0] x;
    logic [8:0] y;
    logic       dx;
    logic       dy;
    int         nb;    // bounce pulses expected during the frame
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_m[$];
  vec_t exp_q[$];

  ball_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .radius     (radius),
    .speed      (speed),
    .collision  (collision),
    .posX       (posX),
    .posY       (posY),
    .dirX       (dirX),
    .dirY       (dirY),
    .moving     (moving),
    .bounce     (bounce)
`ifdef MISS_DETECT_EN
    ,
    .miss       (miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int spd, input int rad, input int coll,
                              input int x, input int y, input int dx,
                              input int dy, input int nb);
    vec_t v;
    v.spd  = 4'(spd);
    v.rad  = 8'(rad);
    v.coll = 1'(coll);
    v.x    = 9'(x);
    v.y    = 9'(y);
    v.dx   = 1'(dx);
    v.dy   = 1'(dy);
    v.nb   = nb;
    return v;
  endfunction

  // One full frame from WAIT_TICK: tick, STEP, SETTLE, RESOLVE, back to WAIT_TICK.
  task automatic run_frame(input string tag, input vec_t v);
    vec_t e;
    int   nb;
    @(negedge clk);
    speed      = v.spd;
    radius     = v.rad;
    frame_tick = 1'b1;
    exp_q.push_back(v);
    nb = 0;
    @(negedge clk);            // now in STEP
    frame_tick = 1'b0;
    @(negedge clk);            // now in SETTLE, stepped position visible
    nb += int'(bounce);
    @(negedge clk);            // now in RESOLVE
    nb += int'(bounce);
    collision = v.coll;
    @(negedge clk);            // back in WAIT_TICK
    nb += int'(bounce);
    collision = 1'b0;
    e = exp_q.pop_front();
    check({tag, " posX"},   int'(posX),   int'(e.x));
    check({tag, " posY"},   int'(posY),   int'(e.y));
    check({tag, " dirX"},   int'(dirX),   int'(e.dx));
    check({tag, " dirY"},   int'(dirY),   int'(e.dy));
    check({tag, " bounces"}, nb,          e.nb);
    check({tag, " moving"}, int'(moving), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_home(input string tag, input int mov);
    check({tag, " posX"},   int'(posX),   200);
    check({tag, " posY"},   int'(posY),   150);
    check({tag, " dirX"},   int'(dirX),   1);
    check({tag, " dirY"},   int'(dirY),   1);
    check({tag, " moving"}, int'(moving), mov);
    check({tag, " bounce"}, int'(bounce), 0);
  endtask

  initial begin
    // Phase A: serve, five slow frames, march right, hit the right wall.
    tab_a.push_back(mk(3, 10, 0, 203, 153, 1, 1, 0));
    tab_a.push_back(mk(3, 10, 0, 206, 156, 1, 1, 0));
    tab_a.push_back(mk(3, 10, 0, 209, 159, 1, 1, 0));
    tab_a.push_back(mk(3, 10, 0, 212, 162, 1, 1, 0));
    tab_a.push_back(mk(3, 10, 0, 215, 165, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 230, 180, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 245, 195, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 260, 210, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 275, 225, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 290, 240, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 305, 255, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 320, 270, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 335, 285, 1, 1, 0));
    tab_a.push_back(mk(15, 10, 0, 350, 289, 1, 0, 1));   // bottom wall clamp
    tab_a.push_back(mk(15, 10, 0, 365, 274, 1, 0, 0));
    tab_a.push_back(mk(15, 10, 0, 380, 259, 1, 0, 0));
    tab_a.push_back(mk(6, 10, 0, 386, 253, 1, 0, 0));
`ifndef MISS_DETECT_EN
    tab_a.push_back(mk(5, 10, 0, 389, 248, 0, 0, 1));    // right wall clamp
`endif
    // Phase B: collisions, wall+collision, frozen ball.
    tab_b.push_back(mk(4, 10, 1, 200, 150, 0, 1, 1));    // 200->204 reverted
    tab_b.push_back(mk(4, 148, 1, 200, 150, 1, 0, 2));   // Y wall then revert
    tab_b.push_back(mk(0, 10, 1, 200, 150, 0, 0, 1));    // speed 0, hit flips dirX
    tab_b.push_back(mk(0, 10, 0, 200, 150, 0, 0, 0));    // speed 0, frozen
    tab_b.push_back(mk(2, 10, 0, 198, 148, 0, 0, 0));
    // Miss build: head left to x=12.
    tab_m.push_back(mk(0, 10, 1, 200, 150, 0, 1, 1));
    tab_m.push_back(mk(15, 10, 0, 185, 165, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 170, 180, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 155, 195, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 140, 210, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 125, 225, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 110, 240, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 95, 255, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 80, 270, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 65, 285, 0, 1, 0));
    tab_m.push_back(mk(15, 10, 0, 50, 289, 0, 0, 1));
    tab_m.push_back(mk(15, 10, 0, 35, 274, 0, 0, 0));
    tab_m.push_back(mk(15, 10, 0, 20, 259, 0, 0, 0));
    tab_m.push_back(mk(8, 10, 0, 12, 251, 0, 0, 0));

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    collision  = 1'b0;
    speed      = 4'd3;
    radius     = 8'd10;
    repeat (2) @(negedge clk);
    check_home("reset", 0);
    rst_n = 1'b1;

    // Tick alone in IDLE is ignored.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_home("idle tick", 0);

    // start and tick together: serve happens, tick is dropped.
    @(negedge clk);
    start      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check_home("start+tick", 1);

    for (int i = 0; i < tab_a.size(); i++)
      run_frame($sformatf("A%0d", i), tab_a[i]);

    // Reset while in STEP: everything back home immediately.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_home("reset mid-step", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_home("after reset idle", 0);

    pulse_start();
    for (int i = 0; i < tab_b.size(); i++)
      run_frame($sformatf("B%0d", i), tab_b[i]);

    // Latency and a tick during SETTLE: exactly one step of 2 per axis.
    @(negedge clk);
    speed      = 4'd2;
    frame_tick = 1'b1;
    @(negedge clk);            // STEP: not updated yet
    frame_tick = 1'b0;
    check("latency STEP posX", int'(posX), 198);
    @(negedge clk);            // SETTLE: updated
    check("latency SETTLE posX", int'(posX), 196);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("settle tick posX", int'(posX), 196);
    check("settle tick posY", int'(posY), 146);
    run_frame("after settle tick", mk(2, 10, 0, 194, 144, 0, 0, 0));

`ifdef MISS_DETECT_EN
    begin
      int nm;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      for (int i = 0; i < tab_m.size(); i++)
        run_frame($sformatf("M%0d", i), tab_m[i]);
      nm = 0;
      @(negedge clk);
      speed      = 4'd4;
      radius     = 8'd10;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        nm += int'(miss);
      end
      check("miss pulses", nm, 1);
      check("miss posX", int'(posX), 200);
      check("miss posY", int'(posY), 150);
      check("miss dirX", int'(dirX), 1);
      check("miss moving", int'(moving), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
